// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 registers the opcode and operands; S2 computes and registers result/flags.
// Optional build macro ALU_SAT_EN enables opcodes 1110 (SATADDU) and
// 1111 (SATADDS); without it those opcodes return 0 with op_err set.
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             op_err
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] LP_WIDTH_V = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_NOT  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SRL  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_EQ   = 4'h6;
  localparam logic [3:0] OP_NE   = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_LTU  = 4'hB;
  localparam logic [3:0] OP_LT   = 4'hC;
  localparam logic [3:0] OP_PASS = 4'hD;
`ifdef ALU_SAT_EN
  localparam logic [3:0] OP_SATU = 4'hE;
  localparam logic [3:0] OP_SATS = 4'hF;
`endif

  // S1 registers
  logic             r_s1_valid;
  logic [3:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  // S2 registers
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_flag_c;
  logic             r_flag_v;
  logic             r_op_err;

  // handshake and datapath wires
  logic             w_adv2;
  logic             w_in_ready;
  logic [WIDTH:0]   w_sum_ext;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_sh;
  logic             w_big;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_err;

  // S2 advances when empty or being drained; S1 follows S2
  assign w_adv2     = !r_s2_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_adv2;

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign alu_out   = r_alu_out;
  assign flag_z    = r_flag_z;
  assign flag_n    = r_flag_n;
  assign flag_c    = r_flag_c;
  assign flag_v    = r_flag_v;
  assign op_err    = r_op_err;

  // shared arithmetic terms for add/sub/shift opcodes
  always_comb begin
    w_sum_ext = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    w_diff    = r_s1_a - r_s1_b;
    w_sh      = r_s1_b[SHW-1:0];
    w_big     = (r_s1_b >= LP_WIDTH_V);
    w_add_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                (w_sum_ext[WIDTH-1] != r_s1_a[WIDTH-1]);
    w_sub_ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);
  end

  // opcode decode: result, carry, overflow and illegal-opcode indication
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_res = w_sum_ext[WIDTH-1:0];
        w_c   = w_sum_ext[WIDTH];
        w_v   = w_add_ovf;
      end
      OP_NOT:  w_res = ~r_s1_b;
      OP_AND:  w_res = r_s1_a & r_s1_b;
      OP_OR:   w_res = r_s1_a | r_s1_b;
      OP_SRL:  w_res = w_big ? '0 : (r_s1_a >> w_sh);
      OP_SLL:  w_res = w_big ? '0 : (r_s1_a << w_sh);
      OP_EQ:   w_res = WIDTH'(r_s1_a == r_s1_b);
      OP_NE:   w_res = WIDTH'(r_s1_a != r_s1_b);
      OP_SUB: begin
        w_res = w_diff;
        w_c   = (r_s1_a >= r_s1_b);
        w_v   = w_sub_ovf;
      end
      OP_XOR:  w_res = r_s1_a ^ r_s1_b;
      OP_SRA:  w_res = w_big ? {WIDTH{r_s1_a[WIDTH-1]}}
                             : $unsigned($signed(r_s1_a) >>> w_sh);
      OP_LTU:  w_res = WIDTH'(r_s1_a < r_s1_b);
      OP_LT:   w_res = WIDTH'($signed(r_s1_a) < $signed(r_s1_b));
      OP_PASS: w_res = r_s1_a;
`ifdef ALU_SAT_EN
      OP_SATU: begin
        w_res = w_sum_ext[WIDTH] ? '1 : w_sum_ext[WIDTH-1:0];
        w_c   = w_sum_ext[WIDTH];
        w_v   = w_sum_ext[WIDTH];
      end
      OP_SATS: begin
        // clamp toward the sign of the operands on overflow
        if (w_add_ovf) begin
          w_res = r_s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
          w_res = w_sum_ext[WIDTH-1:0];
        end
        w_c = w_sum_ext[WIDTH];
        w_v = w_add_ovf;
      end
`endif
      default: begin
        w_res = '0;
        w_err = 1'b1;
      end
    endcase
  end

  // S1: capture a beat whenever the slot is free or draining into S2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= alu_op;
        r_s1_a  <= alu_in1;
        r_s1_b  <= alu_in2;
      end
    end
  end

  // S2: register result and flags; hold everything while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_alu_out  <= '0;
      r_flag_z   <= 1'b0;
      r_flag_n   <= 1'b0;
      r_flag_c   <= 1'b0;
      r_flag_v   <= 1'b0;
      r_op_err   <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_alu_out <= w_res;
        r_flag_z  <= (w_res == '0);
        r_flag_n  <= w_res[WIDTH-1];
        r_flag_c  <= w_c;
        r_flag_v  <= w_v;
        r_op_err  <= w_err;
      end
    end
  end

endmodule
